// File: rtl/fetch_queue.sv
// Instruction fetch front-end: sequential fetch address generation, a single-outstanding
// variable-latency imem request/response port, and a {pc, instr} FIFO feeding the core.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t           state, state_nxt;
    logic [31:0]      fetch_pc;
    logic [31:0]      req_pc;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count, count_nxt;
    logic [31:0]      fifo_pc    [DEPTH];
    logic [31:0]      fifo_instr [DEPTH];
    logic             accept, push, pop;

    assign accept = (state == REQ) && imem_ready;
    assign push   = (state == WAIT) && imem_rvalid && !redirect;
    assign pop    = instr_valid && instr_ready && !redirect;

    always_comb begin
        count_nxt = count + CNT_W'(push) - CNT_W'(pop);
        if (redirect) count_nxt = '0;
    end

    // Slot checks use the post-edge count, so a request is only reissued when the
    // FIFO can hold its response even without further pops.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (!redirect && count_nxt < FULL) state_nxt = REQ;
            REQ: begin
                if (redirect)        state_nxt = imem_ready ? DROP : IDLE;
                else if (imem_ready) state_nxt = WAIT;
            end
            WAIT: begin
                if (imem_rvalid)   state_nxt = (!redirect && count_nxt < FULL) ? REQ : IDLE;
                else if (redirect) state_nxt = DROP;
            end
            DROP: if (imem_rvalid) state_nxt = (!redirect && count_nxt < FULL) ? REQ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (redirect)    fetch_pc <= {redirect_pc[31:2], 2'b00};
            else if (accept) fetch_pc <= fetch_pc + 32'd4;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Datapath storage carries no reset; it is only observed through count.
    always_ff @(posedge clk) begin
        if (accept) req_pc <= fetch_pc;
        if (push) begin
            fifo_pc[wr_ptr]    <= req_pc;
            fifo_instr[wr_ptr] <= imem_rdata;
        end
    end

    assign imem_req    = (state == REQ);
    assign imem_addr   = fetch_pc;
    assign instr_valid = (count != '0);
    assign instr       = instr_valid ? fifo_instr[rd_ptr] : 32'd0;
    assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]    : 32'd0;

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction fetch front-end that sits directly upstream of the core's decode/execute datapath.
- Generates sequential fetch addresses and drives a variable-latency instruction-memory request/response interface.
- Buffers returned instructions, each with its PC, in a small FIFO and presents them to the core through a valid/ready handshake.
- Accepts branch/jump redirects from the core, flushing buffered and in-flight instructions.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of 2 and at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  system clock; one clock, all state on its rising edge.
- rst  input  1  reset, asynchronous and active-low; one clock domain.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address, word aligned.
- imem_ready  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  response data valid.
- imem_rdata  input  32  returned instruction word.
- instr_valid  output  1  FIFO head valid.
- instr  output  32  FIFO head instruction.
- instr_pc  output  32  PC of the FIFO head.
- instr_ready  input  1  core consumes the head this cycle.
- redirect  input  1  taken branch/jump; flush and refetch.
- redirect_pc  input  32  new fetch PC; bits [1:0] are ignored and forced to 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - fetch_pc=RESET_PC, FIFO empty, state=IDLE.
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
- FIFO: DEPTH entries of {pc, instr}; read/write pointers wrap modulo DEPTH; count ranges 0..DEPTH.
  - Pop when instr_valid & instr_ready. Push when an accepted response arrives.
  - Push and pop in the same cycle leave count unchanged.
- Slot reservation: a request is issued only if count + inflight < DEPTH, where inflight=1 in REQ or WAIT. Overflow is therefore impossible.
- State machine:
  - IDLE: if a slot is free and there is no redirect, go to REQ with imem_req=1 and imem_addr=fetch_pc.
  - REQ: imem_req=1, and imem_addr stays stable until imem_ready.
    - On imem_ready: latch req_pc=fetch_pc, fetch_pc+=4, go to WAIT.
  - WAIT: on imem_rvalid, push {req_pc, imem_rdata}.
    - If a slot is still free, go straight to REQ. imem_req rises the cycle after rvalid, so there is no combinational path from rvalid to req.
    - Otherwise go to IDLE.
  - DROP: on imem_rvalid, discard the data and go to IDLE (or REQ if a slot is free).
- Maximum of one outstanding request. imem_rvalid is ignored in IDLE and REQ.
- Latency:
  - Response on cycle N gives instr_valid=1 on cycle N+1.
  - From reset release, the earliest imem_req is the first clock edge after release.
- Redirect:
  - Highest priority; overrides push and pop in the same cycle.
  - FIFO is flushed (count=0, instr_valid=0 next cycle) and fetch_pc=redirect_pc & ~3.
  - In REQ (not yet accepted): imem_req is withdrawn and the state goes to IDLE. This is the only legal withdrawal of imem_req. If imem_ready coincides with redirect, the request counts as accepted and the state goes to DROP.
  - In WAIT: go to DROP. If imem_rvalid arrives in the same cycle as redirect, that data is discarded and the state goes to IDLE.
  - In DROP: remain in DROP. A new redirect only updates fetch_pc.
  - In IDLE: fetch_pc is updated.
- fetch_pc wraps from 32'hFFFF_FFFC to 32'h0000_0000.
- Outputs instr and instr_pc reflect the FIFO head and are don't-care while instr_valid=0.
- Reset asserted mid-transaction: all state clears immediately. A late imem_rvalid after reset release is ignored because the state is IDLE.

Test Plan:
1. Straight-line fetch:
   - Stimulus: reset release, memory with 1-cycle latency, always ready, instr_ready=1.
   - Required: imem_addr sequence 0,4,8,C. Core receives instr_pc 0,4,8,C with matching rdata, in order.
2. Backpressure:
   - Stimulus: instr_ready=0, DEPTH=4.
   - Required: exactly 4 requests (0..C), then imem_req=0. After one pop, exactly one new request to 0x10 is issued.
3. Redirect during WAIT:
   - Stimulus: request to 0x8 accepted, redirect=1 with redirect_pc=0x103.
   - Required: response for 0x8 is dropped, FIFO is empty, and the next imem_addr is 0x100 with instr_pc=0x100.
4. Redirect coinciding with imem_ready and with rvalid:
   - Required: neither the accepted request's data nor the coincident response is ever presented. The first output is at redirect_pc.
5. Slow memory:
   - Stimulus: imem_ready low for 3 cycles.
   - Required: imem_req and imem_addr are held stable throughout. With rvalid after 5 cycles, the output order is still correct.
6. Wrap and async reset:
   - Stimulus: redirect to 0xFFFF_FFFC.
   - Required: next address 0x0. Asserting rst mid-WAIT clears outputs with no clock edge. A stray rvalid after release causes no push.
